store_byte_writer: RTL and testbench

- Store-side counterpart of the load byte path. It accepts store requests (address, rs2 data, func3) from the execute stage and turns each one into a byte-enable mask plus lane-replicated write data for the data BRAM write port.
- A small in-order store buffer decouples the core from BRAM write acknowledge latency.
- Sits between the load/store decode logic and the data BRAM, alongside the load-path byte reader.

---
 rtl/store_byte_writer.sv | 172 +++++++++++++++++
 tb/tb_store_byte_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_byte_writer.sv
// Store byte writer: turns sb/sh/sw requests into byte enables and lane-replicated write data,
// then issues them in order from a small store buffer. Optional macro: STORE_MISALIGN_TRAP_EN.
module store_byte_writer #(
  parameter  int unsigned DEPTH       = 2,
  parameter  int unsigned ADDR_WIDTH  = 32,
  localparam int unsigned DATA_WIDTH  = 32,
  localparam int unsigned FUNC3_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [ADDR_WIDTH-1:0]  st_addr,
  input  logic [DATA_WIDTH-1:0]  st_data,
  input  logic [FUNC3_WIDTH-1:0] st_func3,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic [3:0]             mem_we,
  input  logic                   mem_ack,
  output logic                   busy,
  output logic                   illegal,
  output logic                   misalign,
  output logic [ADDR_WIDTH-1:0]  fault_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            we;
  } entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            state, state_next;
  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;

  entry_t            enc, head_next;
  logic [1:0]        off;
  logic              func_ok, mis;
  logic              acc, enq, pop;

  logic              mem_req_d, load_head, ready_d, busy_d, illegal_d;
  logic [ADDR_WIDTH-1:0] fault_d;
`ifdef STORE_MISALIGN_TRAP_EN
  logic              misalign_d;
`endif

  // Request encoding: byte enables, lane replication and word-aligned address
  always_comb begin
    off       = st_addr[1:0];
    func_ok   = 1'b1;
    mis       = 1'b0;
    enc.addr  = {st_addr[ADDR_WIDTH-1:2], 2'b00};
    enc.wdata = st_data;
    enc.we    = 4'b1111;
    case (st_func3)
      3'b000: begin
        enc.we    = 4'b0001 << off;
        enc.wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        enc.we    = 4'b0011 << {off[1], 1'b0};
        enc.wdata = {2{st_data[15:0]}};
`ifdef STORE_MISALIGN_TRAP_EN
        mis       = off[0];
`endif
      end
      3'b010: begin
`ifdef STORE_MISALIGN_TRAP_EN
        mis       = (off != 2'b00);
`endif
      end
      default: func_ok = 1'b0;
    endcase
  end

  // Buffer bookkeeping; head_next bypasses the array when the new entry lands at the head
  always_comb begin
    acc         = st_valid & st_ready;
    enq         = acc & func_ok & ~mis;
    pop         = (state == S_REQ) & mem_ack;
    count_next  = count - CNT_W'(pop) + CNT_W'(enq);
    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    head_next   = (enq && (wr_ptr == rd_ptr_next)) ? enc : fifo_q[rd_ptr_next];
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (count != '0) state_next = S_REQ;
      S_REQ:   if (pop && (count_next == '0)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output next values; st_ready depends only on the registered count
  always_comb begin
    mem_req_d  = (state_next == S_REQ);
    load_head  = mem_req_d;
    ready_d    = (count_next < CNT_W'(DEPTH));
    busy_d     = (count_next != '0) | mem_req_d;
    illegal_d  = acc & ~func_ok;
`ifdef STORE_MISALIGN_TRAP_EN
    misalign_d = acc & mis;
    fault_d    = (illegal_d | misalign_d) ? st_addr : fault_addr;
`else
    fault_d    = illegal_d ? st_addr : fault_addr;
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      st_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= '0;
      busy       <= 1'b0;
      illegal    <= 1'b0;
      fault_addr <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      rd_ptr     <= rd_ptr_next;
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      st_ready   <= ready_d;
      mem_req    <= mem_req_d;
      busy       <= busy_d;
      illegal    <= illegal_d;
      fault_addr <= fault_d;
      if (load_head) begin
        mem_addr  <= head_next.addr;
        mem_wdata <= head_next.wdata;
        mem_we    <= head_next.we;
      end
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= misalign_d;
  end
`else
  assign misalign = 1'b0;
`endif

  // Store buffer storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (enq) begin
      fifo_q[wr_ptr] <= enc;
    end
  end

endmodule

// File: tb/tb_store_byte_writer.sv
// Bench for store_byte_writer: directed vectors, multi-cycle corner sequences and a
// randomized run against a queue-based reference model.
module tb_store_byte_writer;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_func3;
  logic          mem_req, mem_ack, busy, illegal, misalign;
  logic [AW-1:0] mem_addr, fault_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;

  always #5 clk = ~clk;

  store_byte_writer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_func3(st_func3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .illegal(illegal), .misalign(misalign),
    .fault_addr(fault_addr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_we;
    bit          exp_ill;
    bit          exp_mis;
  } vec_t;

  // Reference encoding from access size and byte offset
  function automatic void ref_encode(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                     output bit ok, output bit mis, output wr_t w);
    int size, o;
    ok = (f3 <= 3'd2);
    mis = 1'b0;
    w.addr = '0; w.wdata = '0; w.we = '0;
    if (!ok) return;
    size = 1 << f3;
    o = int'(a % 4);
`ifdef STORE_MISALIGN_TRAP_EN
    if ((o % size) != 0) begin
      mis = 1'b1;
      return;
    end
`endif
    o = o - (o % size);
    w.addr = a - (a % 4);
    w.we = 4'(((1 << size) - 1) << o);
    for (int i = 0; i < 4; i++) w.wdata[8*i +: 8] = d[8*(i % size) +: 8];
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string tag = $sformatf("vec%0d", idx);
    chk({tag, ".ready"}, st_ready, 1);
    st_valid = 1'b1; st_func3 = v.f3; st_addr = v.addr; st_data = v.data;
    @(negedge clk);
    st_valid = 1'b0;
    chk({tag, ".illegal"}, illegal, v.exp_ill);
    chk({tag, ".misalign"}, misalign, v.exp_mis);
    if (v.exp_ill || v.exp_mis) chk({tag, ".fault_addr"}, fault_addr, v.addr);
    chk({tag, ".req_early"}, mem_req, 0);
    chk({tag, ".busy_enq"}, busy, v.exp_wr);
    @(negedge clk);
    chk({tag, ".illegal_pulse"}, illegal, 0);
    chk({tag, ".misalign_pulse"}, misalign, 0);
    chk({tag, ".req"}, mem_req, v.exp_wr);
    if (v.exp_wr) begin
      chk({tag, ".addr"}, mem_addr, v.exp_addr);
      chk({tag, ".we"}, mem_we, v.exp_we);
      chk({tag, ".wdata"}, mem_wdata, v.exp_wdata);
      @(negedge clk);
      chk({tag, ".req_hold"}, mem_req, 1);
      chk({tag, ".addr_hold"}, mem_addr, v.exp_addr);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, ".req_done"}, mem_req, 0);
      chk({tag, ".busy_done"}, busy, 0);
    end else begin
      chk({tag, ".busy_idle"}, busy, 0);
    end
  endtask

  task automatic run_b2b();
    st_valid = 1'b1; st_func3 = 3'b010; st_addr = 32'h500; st_data = 32'h1111_1111;
    @(negedge clk);
    chk("b2b.ready1", st_ready, 1);
    st_addr = 32'h504; st_data = 32'h2222_2222;
    @(negedge clk);
    chk("b2b.ready_full", st_ready, 0);
    chk("b2b.req", mem_req, 1);
    chk("b2b.addr0", mem_addr, 32'h500);
    st_addr = 32'h508; st_data = 32'h3333_3333;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b2b.stall%0d.ready", i), st_ready, 0);
      chk($sformatf("b2b.stall%0d.req", i), mem_req, 1);
      chk($sformatf("b2b.stall%0d.addr", i), mem_addr, 32'h500);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.ready_after_ack", st_ready, 1);
    chk("b2b.req1", mem_req, 1);
    chk("b2b.addr1", mem_addr, 32'h504);
    chk("b2b.wdata1", mem_wdata, 32'h2222_2222);
    @(negedge clk);
    st_valid = 1'b0;
    chk("b2b.ready_refull", st_ready, 0);
    chk("b2b.addr1_hold", mem_addr, 32'h504);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("b2b.req2", mem_req, 1);
    chk("b2b.addr2", mem_addr, 32'h508);
    chk("b2b.wdata2", mem_wdata, 32'h3333_3333);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.req_end", mem_req, 0);
    chk("b2b.busy_end", busy, 0);
    chk("b2b.ready_end", st_ready, 1);
  endtask

  task automatic run_reset_mid();
    st_valid = 1'b1; st_func3 = 3'b010; st_addr = 32'h600; st_data = 32'hAAAA_0001;
    @(negedge clk);
    st_addr = 32'h604; st_data = 32'hAAAA_0002;
    @(negedge clk);
    st_valid = 1'b0;
    chk("rst.pre_req", mem_req, 1);
    chk("rst.pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.req_now", mem_req, 0);
    chk("rst.busy_now", busy, 0);
    chk("rst.we_now", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst.quiet%0d.req", i), mem_req, 0);
      chk($sformatf("rst.quiet%0d.busy", i), busy, 0);
    end
  endtask

  task automatic run_random(input int n);
    wr_t         q[$];
    wr_t         w;
    bit          m_req = 1'b0, m_ill = 1'b0, m_mis = 1'b0;
    logic [31:0] m_fault = '0;
    bit          acc, pop, ok, mis;
    int          sz, r;
    for (int c = 0; c < n; c++) begin
      chk("rnd.ready", st_ready, q.size() < DEPTH);
      chk("rnd.req", mem_req, m_req);
      chk("rnd.busy", busy, (q.size() != 0) || m_req);
      chk("rnd.illegal", illegal, m_ill);
      chk("rnd.misalign", misalign, m_mis);
      chk("rnd.fault_addr", fault_addr, m_fault);
      if (m_req) begin
        chk("rnd.addr", mem_addr, q[0].addr);
        chk("rnd.we", mem_we, q[0].we);
        chk("rnd.wdata", mem_wdata, q[0].wdata);
      end
      r = $urandom_range(0, 7);
      st_valid = ($urandom_range(0, 2) != 0);
      st_func3 = (r < 5) ? 3'(r % 3) : ((r == 5) ? 3'b011 : 3'(r));
      st_addr  = $urandom;
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) != 0);
      acc = st_valid && (q.size() < DEPTH);
      ref_encode(st_func3, st_addr, st_data, ok, mis, w);
      sz  = q.size();
      pop = m_req && mem_ack;
      if (pop) void'(q.pop_front());
      if (acc && ok && !mis) q.push_back(w);
      m_ill = acc && !ok;
      m_mis = acc && ok && mis;
      if (m_ill || m_mis) m_fault = st_addr;
      m_req = m_req ? (pop ? (q.size() != 0) : 1'b1) : (sz != 0);
      @(negedge clk);
    end
    st_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0] = '{3'b000, 32'h103,  32'h0000_00A5, 1, 32'h100, 32'hA5A5_A5A5, 4'b1000, 0, 0};
    vecs[1] = '{3'b001, 32'h202,  32'h1234_BEEF, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100, 0, 0};
    vecs[2] = '{3'b010, 32'h204,  32'hCAFE_F00D, 1, 32'h204, 32'hCAFE_F00D, 4'b1111, 0, 0};
    vecs[3] = '{3'b000, 32'h000,  32'h1122_3344, 1, 32'h000, 32'h4444_4444, 4'b0001, 0, 0};
    vecs[4] = '{3'b001, 32'h010,  32'hAAAA_5555, 1, 32'h010, 32'h5555_5555, 4'b0011, 0, 0};
    vecs[5] = '{3'b000, 32'h007,  32'h0000_00FF, 1, 32'h004, 32'hFFFF_FFFF, 4'b1000, 0, 0};
    vecs[6] = '{3'b000, 32'hA0A,  32'h0000_00C3, 1, 32'hA08, 32'hC3C3_C3C3, 4'b0100, 0, 0};
    vecs[7] = '{3'b011, 32'h040,  32'h1234_5678, 0, 32'h0,   32'h0,         4'b0000, 1, 0};
    vecs[8] = '{3'b101, 32'h1234, 32'h0BAD_0BAD, 0, 32'h0,   32'h0,         4'b0000, 1, 0};
`ifdef STORE_MISALIGN_TRAP_EN
    vecs[9]  = '{3'b010, 32'h302, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 4'b0000, 0, 1};
    vecs[10] = '{3'b001, 32'h203, 32'h1234_BEEF, 0, 32'h0, 32'h0, 4'b0000, 0, 1};
    vecs[11] = '{3'b001, 32'h001, 32'h0000_ABCD, 0, 32'h0, 32'h0, 4'b0000, 0, 1};
`else
    vecs[9]  = '{3'b010, 32'h302, 32'hCAFE_F00D, 1, 32'h300, 32'hCAFE_F00D, 4'b1111, 0, 0};
    vecs[10] = '{3'b001, 32'h203, 32'h1234_BEEF, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100, 0, 0};
    vecs[11] = '{3'b001, 32'h001, 32'h0000_ABCD, 1, 32'h000, 32'hABCD_ABCD, 4'b0011, 0, 0};
`endif

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_func3 = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.mem_req", mem_req, 0);
    chk("reset.mem_addr", mem_addr, 0);
    chk("reset.mem_wdata", mem_wdata, 0);
    chk("reset.mem_we", mem_we, 0);
    chk("reset.busy", busy, 0);
    chk("reset.illegal", illegal, 0);
    chk("reset.misalign", misalign, 0);
    chk("reset.fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.ready", st_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    run_b2b();
    run_reset_mid();
    run_random(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
